// File: rtl/walk_request_conditioner.sv
// Pedestrian push-button conditioner: synchronise, debounce, latch, serve a bounded walk pulse on RED, then cool down.
// Optional chirp output enabled by defining WALK_CHIRP_EN.
module walk_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 2,
    parameter int COOLDOWN_CYCLES = 8
`ifdef WALK_CHIRP_EN
    ,
    parameter int CHIRP_DIV       = 2
`endif
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       btn_i,
    input  logic [1:0] signal_i,
    output logic       walk_o,
    output logic       pending_o,
    output logic       cooldown_o
`ifdef WALK_CHIRP_EN
    ,
    output logic       chirp_o
`endif
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_CYCLES - 1);

    localparam logic [1:0] SIG_RED = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RED,
        ST_ASSERT,
        ST_COOLDOWN
    } state_t;

    state_t        state, state_nxt;
    logic          btn_s1, btn_s, btn_db;
    logic [DW-1:0] stab_ctr;
    logic [PW-1:0] pulse_ctr, pulse_nxt;
    logic [CW-1:0] cool_ctr, cool_nxt;
    logic          pending, pending_nxt;
    logic          db_rise;
    logic          is_red;

    assign is_red  = (signal_i == SIG_RED);
    assign db_rise = (btn_s != btn_db) && !btn_db && (stab_ctr == DB_LAST);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            btn_s1   <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            stab_ctr <= '0;
        end else begin
            btn_s1 <= btn_i;
            btn_s  <= btn_s1;
            if (btn_s == btn_db) begin
                stab_ctr <= '0;
            end else if (stab_ctr == DB_LAST) begin
                btn_db   <= btn_s;
                stab_ctr <= '0;
            end else begin
                stab_ctr <= stab_ctr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            pulse_ctr <= '0;
            cool_ctr  <= '0;
            pending   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pulse_ctr <= pulse_nxt;
            cool_ctr  <= cool_nxt;
            pending   <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pulse_nxt   = pulse_ctr;
        cool_nxt    = cool_ctr;
        pending_nxt = pending;
        case (state)
            ST_IDLE: begin
                if (db_rise) begin
                    pending_nxt = 1'b1;
                    state_nxt   = ST_WAIT_RED;
                end
            end
            ST_WAIT_RED: begin
                if (is_red) begin
                    state_nxt = ST_ASSERT;
                    pulse_nxt = '0;
                end
            end
            ST_ASSERT: begin
                // Presses landing here are dropped; the request is already latched.
                if (!is_red) begin
                    state_nxt = ST_WAIT_RED;
                    pulse_nxt = '0;
                end else if (pulse_ctr == PULSE_LAST) begin
                    state_nxt   = ST_COOLDOWN;
                    pending_nxt = 1'b0;
                    cool_nxt    = '0;
                end else begin
                    pulse_nxt = pulse_ctr + 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (db_rise) begin
                    pending_nxt = 1'b1;
                end
                if (cool_ctr == COOL_LAST) begin
                    state_nxt = (pending || db_rise) ? ST_WAIT_RED : ST_IDLE;
                end else begin
                    cool_nxt = cool_ctr + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign walk_o     = (state == ST_ASSERT) && is_red;
    assign pending_o  = pending;
    assign cooldown_o = (state == ST_COOLDOWN);

`ifdef WALK_CHIRP_EN
    localparam int HW = $clog2(CHIRP_DIV + 1);
    localparam logic [HW-1:0] CHIRP_LAST = HW'(CHIRP_DIV - 1);

    logic [HW-1:0] chirp_ctr;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            chirp_ctr <= '0;
            chirp_o   <= 1'b0;
        end else if (!walk_o) begin
            chirp_ctr <= '0;
            chirp_o   <= 1'b0;
        end else if (chirp_ctr == CHIRP_LAST) begin
            chirp_ctr <= '0;
            chirp_o   <= ~chirp_o;
        end else begin
            chirp_ctr <= chirp_ctr + 1'b1;
        end
    end
`endif

endmodule

// File: doc/walk_request_conditioner.md
Name: walk_request_conditioner

Overview:
- Upstream stage of the traffic light controller; produces its walk request input.
- Synchronises and debounces the raw pedestrian push-button, latches a request, and issues a bounded walk pulse only while the controller shows RED.
- Enforces a cooldown after each served request so a held or hammered button cannot keep the light red indefinitely.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before the debounced level changes (>=1).
- PULSE_LEN, 2, number of cycles walk_o is driven high per served request (>=1).
- COOLDOWN_CYCLES, 8, cycles after a served request before a new request may be served (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- btn_i  input  1  raw pedestrian button; asynchronous and bouncy.
- signal_i  input  2  current light from the controller: 0=RED, 1=GREEN, 2=YELLOW, 3=invalid (treated as not RED).
- walk_o  output  1  walk request to the controller.
- pending_o  output  1  request latched and not yet served.
- cooldown_o  output  1  high while in COOLDOWN.

Behaviour:
- Reset (async, rst_i=1): sync flops=0, btn_db=0, counters=0, pending=0, state=IDLE. walk_o=0, pending_o=0, cooldown_o=0. Release is synchronous to clk.
- Synchroniser: two flops, btn_i -> btn_s1 -> btn_s.
- Debounce:
  - stab_ctr clears whenever btn_s==btn_db.
  - Otherwise it increments. On the edge where btn_s!=btn_db and stab_ctr==DEBOUNCE_CYCLES-1: btn_db<=btn_s and stab_ctr<=0.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Rise detect: db_rise = btn_s!=btn_db && btn_db==0 && stab_ctr==DEBOUNCE_CYCLES-1, i.e. the edge on which btn_db goes 0->1. Falling debounced edges are ignored.
- Pending flag:
  - Set on db_rise in IDLE or COOLDOWN.
  - Ignored in WAIT_RED (already set) and in ASSERT.
  - Cleared on the edge leaving ASSERT on pulse completion.
  - pending_o = pending register.
- FSM states and transitions:
  - IDLE: db_rise -> WAIT_RED.
  - WAIT_RED: signal_i==RED -> ASSERT, pulse_ctr<=0. Otherwise stay.
  - ASSERT:
    - If signal_i!=RED: abort -> WAIT_RED; pending stays 1, pulse_ctr<=0.
    - Else if pulse_ctr==PULSE_LEN-1: -> COOLDOWN, pending<=0, cool_ctr<=0.
    - Else pulse_ctr++.
  - COOLDOWN: cool_ctr++. On the edge where cool_ctr==COOLDOWN_CYCLES-1: -> WAIT_RED if pending (including a db_rise on that same edge), else -> IDLE.
- Outputs:
  - walk_o = (state==ASSERT) && (signal_i==RED), combinational. It is never high while signal_i!=RED.
  - cooldown_o = (state==COOLDOWN), registered state decode.
- Latency:
  - btn_i rise to pending_o rise: 2+DEBOUNCE_CYCLES edges.
  - WAIT_RED with RED to walk_o high: 1 edge.
  - walk_o stays high for exactly PULSE_LEN cycles if RED is held.
- Simultaneous events: a db_rise on the edge an ASSERT completes is dropped. A btn_i change during reset has no effect.

Optional Feature:
- Macro: WALK_CHIRP_EN.
- When defined:
  - Adds output chirp_o (1 bit) and parameter CHIRP_DIV (default 2).
  - chirp_o toggles every CHIRP_DIV cycles while walk_o is high.
  - chirp_o forced to 0 otherwise; the divider clears whenever walk_o is low.
  - Reset value of chirp_o is 0.
- When undefined: no chirp_o port and no divider logic. All other behaviour is identical.

Test Plan:
- Clean press: btn_i 0->1 held 10 cycles, signal_i=GREEN -> pending_o rises exactly 6 edges after btn_i; walk_o stays 0.
- Bounce rejection: btn_i high for 3 cycles then low -> btn_db never rises; pending_o stays 0; state stays IDLE.
- Serve: pending_o=1, signal_i switches to RED -> walk_o high for exactly 2 cycles starting 1 edge later; pending_o falls with walk_o; cooldown_o high for 8 cycles; then IDLE.
- Abort: in ASSERT after 1 cycle, signal_i -> YELLOW -> walk_o drops immediately; pending_o stays 1. On the next RED, a full 2-cycle pulse is issued.
- Press in cooldown: debounced press during COOLDOWN -> pending_o=1; no walk_o until cooldown ends; then WAIT_RED; with RED, walk_o pulses 2 cycles.
- Mid-operation reset: rst_i asserted during ASSERT -> walk_o, pending_o, cooldown_o all 0 asynchronously, before the next clk edge. After release with btn_i held high, a new request is latched after 6 edges.
